// File: rtl/mem_access_stage.sv
// RV32I MEM stage: drives the data bus for loads/stores, aligns load data and
// stalls the upstream pipeline while a bus access is outstanding.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_ALUResult_32,
    input  logic        i_Load_1,
    input  logic        i_Store_1,
    input  logic        i_LoadUnsigned_1,
    input  logic [1:0]  i_LoadStoreWidth_2,
    input  logic [31:0] i_StoreData_32,
    input  logic [4:0]  i_GRFWriteAddr_5,
    input  logic        i_GRFWen_1,
    output logic        o_Stall_1,
    output logic        o_MisalignFault_1,
    output logic        o_BusError_1,
    output logic [31:0] o_WBData_32,
    output logic [4:0]  o_GRFWriteAddr_5,
    output logic        o_GRFWen_1,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t          state, state_next;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W:0]   to_next;
    logic            to_hit;
    logic            is_mem, misalign, start;
    logic            op_load, op_unsigned, op_wen, bus_err;
    logic [1:0]      op_width, op_addr_lo;
    logic [4:0]      op_rd;
    logic [31:0]     load_data, load_ext;
    logic [31:0]     byte_sh, half_sh;
    logic [3:0]      st_wstrb;
    logic [31:0]     st_wdata;

    assign is_mem   = i_Load_1 | i_Store_1;
    assign misalign = is_mem &
                      ((i_LoadStoreWidth_2 == 2'b11) ||
                       (i_LoadStoreWidth_2 == 2'b01 && i_ALUResult_32[0]) ||
                       (i_LoadStoreWidth_2 == 2'b10 && i_ALUResult_32[1:0] != 2'b00));
    assign start    = (state == IDLE) && is_mem && !misalign;

    // Counting this cycle reaches TIMEOUT: bail out at the end of the cycle.
    assign to_next = {1'b0, to_cnt} + {{TO_W{1'b0}}, 1'b1};
    assign to_hit  = (TIMEOUT != 0) && (to_next == (TO_W+1)'(TIMEOUT));

    always_comb begin
        st_wstrb = '0;
        st_wdata = '0;
        if (!i_Load_1) begin
            case (i_LoadStoreWidth_2)
                2'b00: begin
                    st_wstrb = 4'b0001 << i_ALUResult_32[1:0];
                    st_wdata = {4{i_StoreData_32[7:0]}};
                end
                2'b01: begin
                    st_wstrb = 4'b0011 << i_ALUResult_32[1:0];
                    st_wdata = {2{i_StoreData_32[15:0]}};
                end
                default: begin
                    st_wstrb = 4'hF;
                    st_wdata = i_StoreData_32;
                end
            endcase
        end
    end

    assign byte_sh = dmem_rdata >> {op_addr_lo, 3'b000};
    assign half_sh = dmem_rdata >> {op_addr_lo[1], 4'b0000};

    always_comb begin
        case (op_width)
            2'b00:   load_ext = op_unsigned ? {24'h0, byte_sh[7:0]}
                                            : {{24{byte_sh[7]}}, byte_sh[7:0]};
            2'b01:   load_ext = op_unsigned ? {16'h0, half_sh[15:0]}
                                            : {{16{half_sh[15]}}, half_sh[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = REQ;
            REQ:     if (dmem_gnt) state_next = op_load ? WAIT_R : DONE;
                     else if (to_hit) state_next = DONE;
            WAIT_R:  if (dmem_rvalid || to_hit) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wstrb  <= '0;
            dmem_wdata  <= '0;
            op_load     <= 1'b0;
            op_unsigned <= 1'b0;
            op_wen      <= 1'b0;
            op_width    <= '0;
            op_addr_lo  <= '0;
            op_rd       <= '0;
            bus_err     <= 1'b0;
            load_data   <= '0;
            to_cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dmem_req    <= 1'b1;
                    dmem_we     <= ~i_Load_1;
                    dmem_addr   <= {i_ALUResult_32[31:2], 2'b00};
                    dmem_wstrb  <= st_wstrb;
                    dmem_wdata  <= st_wdata;
                    op_load     <= i_Load_1;
                    op_unsigned <= i_LoadUnsigned_1;
                    op_wen      <= i_GRFWen_1;
                    op_width    <= i_LoadStoreWidth_2;
                    op_addr_lo  <= i_ALUResult_32[1:0];
                    op_rd       <= i_GRFWriteAddr_5;
                    bus_err     <= 1'b0;
                    load_data   <= '0;
                    to_cnt      <= '0;
                end
                REQ: begin
                    to_cnt <= to_next[TO_W-1:0];
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                    end else if (to_hit) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                    end
                end
                WAIT_R: begin
                    to_cnt <= to_next[TO_W-1:0];
                    if (dmem_rvalid) load_data <= load_ext;
                    else if (to_hit) bus_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_Stall_1         = 1'b0;
        o_MisalignFault_1 = 1'b0;
        o_BusError_1      = 1'b0;
        o_WBData_32       = i_ALUResult_32;
        o_GRFWriteAddr_5  = i_GRFWriteAddr_5;
        o_GRFWen_1        = i_GRFWen_1;
        case (state)
            IDLE: begin
                if (misalign) begin
                    o_MisalignFault_1 = 1'b1;
                    o_GRFWen_1        = 1'b0;
                end else if (start) begin
                    o_Stall_1  = 1'b1;
                    o_GRFWen_1 = 1'b0;
                end
            end
            REQ, WAIT_R: begin
                o_Stall_1        = 1'b1;
                o_WBData_32      = '0;
                o_GRFWriteAddr_5 = op_rd;
                o_GRFWen_1       = 1'b0;
            end
            default: begin
                o_BusError_1     = bus_err;
                o_WBData_32      = op_load ? load_data : '0;
                o_GRFWriteAddr_5 = op_rd;
                o_GRFWen_1       = op_load & op_wen & ~bus_err;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected write-back pushed at issue,
// compared when the stage releases its stall.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] alu_result;
    logic        load, store, load_unsigned;
    logic [1:0]  width;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        wen_in;
    logic        stall, misalign_fault, bus_error;
    logic [31:0] wb_data;
    logic [4:0]  rd_out;
    logic        wen_out;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] wb;
        logic        wen;
        logic [4:0]  rd;
        logic        berr;
        int          stalls;
    } exp_t;
    exp_t sb[$];

    mem_access_stage #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rstn(rstn),
        .i_ALUResult_32(alu_result), .i_Load_1(load), .i_Store_1(store),
        .i_LoadUnsigned_1(load_unsigned), .i_LoadStoreWidth_2(width),
        .i_StoreData_32(store_data), .i_GRFWriteAddr_5(rd_in), .i_GRFWen_1(wen_in),
        .o_Stall_1(stall), .o_MisalignFault_1(misalign_fault), .o_BusError_1(bus_error),
        .o_WBData_32(wb_data), .o_GRFWriteAddr_5(rd_out), .o_GRFWen_1(wen_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(logic [31:0] rdata, logic [1:0] a,
                                               logic [1:0] w, logic u);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (w)
            2'b00:   return u ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return u ? {16'h0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(logic [1:0] a, logic [1:0] w);
        case (w)
            2'b00: case (a)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(logic [31:0] sd, logic [1:0] w);
        case (w)
            2'b00:   return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            2'b01:   return {sd[15:0], sd[15:0]};
            default: return sd;
        endcase
    endfunction

    task automatic idle_inputs(input logic [31:0] alu, input logic [4:0] rd, input logic wen);
        alu_result = alu; load = 1'b0; store = 1'b0; load_unsigned = 1'b0;
        width = 2'b00; store_data = '0; rd_in = rd; wen_in = wen;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    // gnt_dly/rv_dly: cycles of req (resp. wait) before the response; -1 = never.
    task automatic run_mem(input string tag, input logic ld, input logic st, input logic uns,
                           input logic [1:0] w, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input int gnt_dly, input int rv_dly);
        exp_t e, got;
        int   bus, req_seen, wait_seen, stalls;
        bit   granted, done;
        logic is_ld;
        is_ld = ld;
        bus = is_ld ? gnt_dly + 1 + rv_dly + 1 : gnt_dly + 1;
        e.berr = (gnt_dly < 0) || (is_ld && rv_dly < 0) || (bus > TO);
        if (e.berr) bus = TO;
        e.stalls = 1 + bus;
        e.wb     = (is_ld && !e.berr) ? model_load(rdata, addr[1:0], w, uns) : 32'h0;
        e.wen    = is_ld && !e.berr;
        e.rd     = rd;
        sb.push_back(e);

        @(posedge clk); #1;
        alu_result = addr; load = ld; store = st; load_unsigned = uns; width = w;
        store_data = sd; rd_in = rd; wen_in = 1'b1; dmem_rdata = rdata;
        @(negedge clk);
        check({tag, "_stall_issue"}, {31'b0, stall}, 32'd1);
        check({tag, "_req_issue"}, {31'b0, dmem_req}, 32'd0);
        stalls = 1; req_seen = 0; wait_seen = 0; granted = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (granted && is_ld) begin
                if (wait_seen == rv_dly) dmem_rvalid = 1'b1;
                wait_seen++;
            end else if (dmem_req && !granted) begin
                if (req_seen == 0) begin
                    check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
                    check({tag, "_we"}, {31'b0, dmem_we}, {31'b0, ~is_ld});
                    check({tag, "_wstrb"}, {28'b0, dmem_wstrb}, is_ld ? 32'h0 : {28'b0, model_strb(addr[1:0], w)});
                    check({tag, "_wdata"}, dmem_wdata, is_ld ? 32'h0 : model_wdata(sd, w));
                end
                if (req_seen == gnt_dly) begin
                    dmem_gnt = 1'b1;
                    granted  = 1;
                end
                req_seen++;
            end
            @(negedge clk);
            if (!stall) done = 1;
            else stalls++;
        end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        got = sb.pop_front();
        if (done) begin
            check({tag, "_stalls"}, stalls, got.stalls);
            check({tag, "_wb"}, wb_data, got.wb);
            check({tag, "_wen"}, {31'b0, wen_out}, {31'b0, got.wen});
            check({tag, "_rd"}, {27'b0, rd_out}, {27'b0, got.rd});
            check({tag, "_buserr"}, {31'b0, bus_error}, {31'b0, got.berr});
            check({tag, "_req_done"}, {31'b0, dmem_req}, 32'd0);
        end
        @(posedge clk); #1;
        idle_inputs(32'h0, 5'd0, 1'b0);
    endtask

    task automatic run_misalign(input string tag, input logic [1:0] w, input logic [31:0] addr);
        @(posedge clk); #1;
        alu_result = addr; load = 1'b1; store = 1'b0; width = w; rd_in = 5'd9; wen_in = 1'b1;
        @(negedge clk);
        check({tag, "_fault"}, {31'b0, misalign_fault}, 32'd1);
        check({tag, "_wen"}, {31'b0, wen_out}, 32'd0);
        check({tag, "_stall"}, {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        idle_inputs(32'h0, 5'd0, 1'b0);
        @(negedge clk);
        check({tag, "_req"}, {31'b0, dmem_req}, 32'd0);
        check({tag, "_fault_clr"}, {31'b0, misalign_fault}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        dmem_rdata = '0;
        idle_inputs(32'h0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        check("rst_wstrb", {28'b0, dmem_wstrb}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);

        // ALU pass-through: same-cycle, no bus activity
        @(posedge clk); #1;
        idle_inputs(32'h1234, 5'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("alu_wb", wb_data, 32'h1234);
            check("alu_wen", {31'b0, wen_out}, 32'd1);
            check("alu_rd", {27'b0, rd_out}, 32'd5);
            check("alu_stall", {31'b0, stall}, 32'd0);
            check("alu_req", {31'b0, dmem_req}, 32'd0);
        end

        run_mem("sb",      1'b0, 1'b1, 1'b0, 2'b00, 32'h103, 32'h000000AB, 32'h0, 5'd1, 2, 0);
        run_mem("sh",      1'b0, 1'b1, 1'b0, 2'b01, 32'h102, 32'h1234BEEF, 32'h0, 5'd2, 0, 0);
        run_mem("sw",      1'b0, 1'b1, 1'b0, 2'b10, 32'h200, 32'hCAFEF00D, 32'h0, 5'd3, 1, 0);
        run_mem("lb",      1'b1, 1'b0, 1'b0, 2'b00, 32'h102, 32'h0, 32'h0080FF00, 5'd4, 0, 0);
        run_mem("lbu",     1'b1, 1'b0, 1'b1, 2'b00, 32'h102, 32'h0, 32'h0080FF00, 5'd6, 1, 1);
        run_mem("lh",      1'b1, 1'b0, 1'b0, 2'b01, 32'h102, 32'h0, 32'h0080FF00, 5'd7, 0, 0);
        run_mem("lh_neg",  1'b1, 1'b0, 1'b0, 2'b01, 32'h100, 32'h0, 32'h1234F00D, 5'd8, 0, 1);
        run_mem("lhu",     1'b1, 1'b0, 1'b1, 2'b01, 32'h100, 32'h0, 32'h1234F00D, 5'd8, 0, 0);
        run_mem("lb_b1",   1'b1, 1'b0, 1'b0, 2'b00, 32'h101, 32'h0, 32'h00007F00, 5'd10, 0, 0);
        run_mem("lw",      1'b1, 1'b0, 1'b0, 2'b10, 32'h304, 32'h0, 32'h89ABCDEF, 5'd11, 1, 1);
        run_mem("ld_prio", 1'b1, 1'b1, 1'b0, 2'b10, 32'h400, 32'h55555555, 32'h13579BDF, 5'd12, 0, 0);

        run_misalign("lw_mis", 2'b10, 32'h106);
        run_misalign("lh_mis", 2'b01, 32'h101);
        run_misalign("w11_mis", 2'b11, 32'h100);

        run_mem("lw_to",   1'b1, 1'b0, 1'b0, 2'b10, 32'h500, 32'h0, 32'hDEADBEEF, 5'd13, 0, -1);
        run_mem("sw_to",   1'b0, 1'b1, 1'b0, 2'b10, 32'h504, 32'h11112222, 32'h0, 5'd14, -1, 0);

        // Reset asserted while waiting for read data; the late rvalid must be ignored
        @(posedge clk); #1;
        alu_result = 32'h600; load = 1'b1; width = 2'b10; rd_in = 5'd15; wen_in = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_req", {31'b0, dmem_req}, 32'd1);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        check("rst_mid_wait_stall", {31'b0, stall}, 32'd1);
        rstn = 1'b0;
        idle_inputs(32'h55, 5'd15, 1'b0);
        #2;
        check("rst_mid_req_low", {31'b0, dmem_req}, 32'd0);
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("rst_late_stall", {31'b0, stall}, 32'd0);
        check("rst_late_wen", {31'b0, wen_out}, 32'd0);
        check("rst_late_wb", wb_data, 32'h55);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check("rst_after_stall", {31'b0, stall}, 32'd0);
        check("rst_after_req", {31'b0, dmem_req}, 32'd0);
        check("rst_after_berr", {31'b0, bus_error}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
